// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg -- shared constants and types for the 3x3 convolution engine.
//   DATA_W/FRAC_W : Q8.8 signed sample format
//   IN_DIM/OUT_DIM: input image edge (32) and valid-conv output edge (30)
//   IN_CH/OUT_CH  : 3 input channels, 8 output channels
//   K             : kernel edge (3)
//   ACC_W         : accumulator width, wide enough for 27 Q16.16 products
//                   plus the shifted bias without overflow
// ---------------------------------------------------------------------------
package cnn_pkg;

    localparam int DATA_W  = 16;
    localparam int FRAC_W  = 8;
    localparam int IN_DIM  = 32;
    localparam int OUT_DIM = 30;
    localparam int IN_CH   = 3;
    localparam int OUT_CH  = 8;
    localparam int K       = 3;

    localparam int TAPS    = K * K;
    localparam int PIX_W   = DATA_W * IN_CH;
    localparam int RES_W   = DATA_W * OUT_CH;
    localparam int ACC_W   = 40;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cnn_pe.sv
// ---------------------------------------------------------------------------
// cnn_pe -- combinational processing element for one output sample.
// Multiplies a 3x3x3 pixel window by the matching 3x3x3 kernel, adds the
// bias (aligned to Q16.16), drops the fraction by arithmetic shift
// (truncation), and saturates to signed 16 bits.
// Optional build macro CNN_RELU_EN clamps negative results to zero.
// Ports:
//   win_i  : 9 taps x 48 bits, tap t = ky*3+kx, channel c at bits [16c+15:16c]
//   wgt_i  : 9 taps x 48 bits, same packing as win_i
//   bias_i : Q8.8 bias for this output channel
//   res_o  : Q8.8 result
// ---------------------------------------------------------------------------
module cnn_pe
    import cnn_pkg::*;
(
    input  logic [TAPS*PIX_W-1:0] win_i,
    input  logic [TAPS*PIX_W-1:0] wgt_i,
    input  logic [DATA_W-1:0]     bias_i,
    output logic [DATA_W-1:0]     res_o
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) <<< (DATA_W-1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -(ACC_W'(1) <<< (DATA_W-1));

    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)
            return DATA_W'(SAT_MAX);
        else if (v < SAT_MIN)
            return DATA_W'(SAT_MIN);
        else
            return v[DATA_W-1:0];
    endfunction

    logic signed [DATA_W-1:0]   px;
    logic signed [DATA_W-1:0]   wx;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [DATA_W-1:0]   bias_s;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    acc_sh;
    logic signed [DATA_W-1:0]   sat;

    always_comb begin
        px     = '0;
        wx     = '0;
        prod   = '0;
        bias_s = bias_i;
        // Bias is Q8.8; shift into the Q16.16 product domain before summing.
        acc    = ACC_W'(bias_s) <<< FRAC_W;
        for (int t = 0; t < TAPS; t++) begin
            for (int ch = 0; ch < IN_CH; ch++) begin
                px   = win_i[t*PIX_W + ch*DATA_W +: DATA_W];
                wx   = wgt_i[t*PIX_W + ch*DATA_W +: DATA_W];
                prod = px * wx;
                acc  = acc + ACC_W'(prod);
            end
        end
        acc_sh = acc >>> FRAC_W;
        sat    = saturate(acc_sh);
    end

`ifdef CNN_RELU_EN
    assign res_o = sat[DATA_W-1] ? '0 : sat;
`else
    assign res_o = sat;
`endif

endmodule

// File: rtl/top_cnn.sv
// ---------------------------------------------------------------------------
// top_cnn -- 30x30x8 valid 3x3 convolution over a 32x32x3 Q8.8 image.
// One (r,c,oc) result is produced per cycle; oc counts fastest, then c, r.
// Sequence after reset release: IDLE (1 cycle) -> CONV (7200 cycles) -> DONE.
// Optional build macro CNN_RELU_EN (passed to cnn_pe) clamps negatives to 0.
// Ports:
//   clk           : rising-edge clock
//   rst           : asynchronous active-low reset
//   cnndonesignal : high once all results are written, until next reset
// Memories (loaded/read hierarchically, never reset):
//   mem_pixel_in[32][32], mem_weight_in[72], mem_bias_in[8], mem_result[30][30]
// ---------------------------------------------------------------------------
module top_cnn
    import cnn_pkg::*;
(
    input  logic clk,
    input  logic rst,
    output logic cnndonesignal
);

    logic [PIX_W-1:0]  mem_pixel_in  [IN_DIM][IN_DIM];
    logic [PIX_W-1:0]  mem_weight_in [OUT_CH*TAPS];
    logic [DATA_W-1:0] mem_bias_in   [OUT_CH];
    logic [RES_W-1:0]  mem_result    [OUT_DIM][OUT_DIM];

    state_t      state_q, state_d;
    logic [4:0]  r_q, r_d;
    logic [4:0]  c_q, c_d;
    logic [2:0]  oc_q, oc_d;
    logic        done_q, done_d;
    logic        conv_en;
    logic        last;

    logic [TAPS*PIX_W-1:0] win;
    logic [TAPS*PIX_W-1:0] wgt;
    logic [6:0]            wbase;
    logic [DATA_W-1:0]     pe_res;

    assign last = (r_q == 5'(OUT_DIM-1)) && (c_q == 5'(OUT_DIM-1)) && (oc_q == 3'(OUT_CH-1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            c_q     <= '0;
            oc_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            oc_q    <= oc_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = CONV;
            CONV:    if (last) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs and counter advance
    always_comb begin
        conv_en = (state_q == CONV);
        // Done is registered so it rises on the same edge that enters DONE.
        done_d  = done_q | (conv_en & last);
        r_d     = r_q;
        c_d     = c_q;
        oc_d    = oc_q;
        if (conv_en && !last) begin
            if (oc_q != 3'(OUT_CH-1)) begin
                oc_d = oc_q + 3'd1;
            end else begin
                oc_d = '0;
                if (c_q != 5'(OUT_DIM-1)) begin
                    c_d = c_q + 5'd1;
                end else begin
                    c_d = '0;
                    r_d = r_q + 5'd1;
                end
            end
        end
    end

    assign cnndonesignal = done_q;

    // Window and kernel gather for the current (r,c,oc)
    assign wbase = 7'(oc_q) * 7'(TAPS);

    always_comb begin
        win = '0;
        wgt = '0;
        for (int ky = 0; ky < K; ky++) begin
            for (int kx = 0; kx < K; kx++) begin
                win[(ky*K+kx)*PIX_W +: PIX_W] = mem_pixel_in[r_q + 5'(ky)][c_q + 5'(kx)];
                wgt[(ky*K+kx)*PIX_W +: PIX_W] = mem_weight_in[wbase + 7'(ky*K+kx)];
            end
        end
    end

    cnn_pe u_pe (
        .win_i  (win),
        .wgt_i  (wgt),
        .bias_i (mem_bias_in[oc_q]),
        .res_o  (pe_res)
    );

    // Result write: only the 16-bit slice for the current output channel.
    always_ff @(posedge clk) begin
        if (conv_en)
            mem_result[r_q][c_q][{oc_q, 4'b0000} +: DATA_W] <= pe_res;
    end

endmodule

// File: tb/tb_top_cnn.sv
module tb_top_cnn;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cnndonesignal;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    top_cnn dut (
        .clk           (clk),
        .rst           (rst),
        .cnndonesignal (cnndonesignal)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [15:0] pv, input logic [15:0] wv, input logic [15:0] bv);
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                dut.mem_pixel_in[r][c] = {3{pv}};
        for (int i = 0; i < 72; i++)
            dut.mem_weight_in[i] = {3{wv}};
        for (int i = 0; i < 8; i++)
            dut.mem_bias_in[i] = bv;
    endtask

    // Hand-derived expected slice per stimulus pattern.
    function automatic logic [15:0] expected(input int mode, input int r, input int c, input int oc);
        case (mode)
            0: return 16'h1B00;                       // 27 x 1.0 x 1.0
            1: begin
                if (oc == 3) begin
`ifdef CNN_RELU_EN
                    return 16'h0000;
`else
                    return 16'hFF00;
`endif
                end
                return 16'h0080;
            end
            2: return 16'h7FFF;
            3: return (r == 4 && c == 5 && oc == 2) ? 16'h0200 : 16'h0000;
            default: return 16'hDEAD;
        endcase
    endfunction

    task automatic check_all(input string tag, input int mode);
        int bad;
        logic [15:0] got;
        bad = 0;
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 30; c++)
                for (int oc = 0; oc < 8; oc++) begin
                    got = dut.mem_result[r][c][oc*16 +: 16];
                    if (got !== expected(mode, r, c, oc)) bad++;
                end
        chk(tag, bad, 0);
    endtask

    // Release reset between edges, then count edges until done (bounded).
    task automatic run(output int n);
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (n < 8000) begin
            @(posedge clk);
            #1;
            n++;
            if (cnndonesignal) break;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;

        // Uniform ones: each output = 27 * 1.0
        rst = 1'b0;
        load(16'h0100, 16'h0100, 16'h0000);
        repeat (3) @(negedge clk);
        chk("rst_done", cnndonesignal, 1'b0);
        run(n);
        chk("t1_latency", n, 7201);
        check_all("t1_all", 0);
        chk("t1_last", dut.mem_result[29][29][127:112], 16'h1B00);

        // DONE is terminal: changed inputs must not be re-processed
        load(16'h0000, 16'h0000, 16'h0000);
        repeat (20) @(negedge clk);
        chk("t1_hold", cnndonesignal, 1'b1);
        chk("t1_nowrite", dut.mem_result[0][0][15:0], 16'h1B00);

        // Bias-only, with one negative bias
        do_reset();
        chk("t2_rst_done", cnndonesignal, 1'b0);
        load(16'h0000, 16'h0000, 16'h0080);
        dut.mem_bias_in[3] = 16'hFF00;
        run(n);
        chk("t2_latency", n, 7201);
        check_all("t2_all", 1);
        chk("t2_oc3", dut.mem_result[12][17][63:48], expected(1, 12, 17, 3));
        chk("t2_oc4", dut.mem_result[12][17][79:64], 16'h0080);

        // Positive saturation
        do_reset();
        load(16'h7FFF, 16'h7FFF, 16'h0000);
        run(n);
        chk("t3_latency", n, 7201);
        check_all("t3_all", 2);

        // Single pixel x single weight: indexing
        do_reset();
        load(16'h0000, 16'h0000, 16'h0000);
        dut.mem_pixel_in[5][7] = {16'h0000, 16'h0200, 16'h0000};
        dut.mem_weight_in[2*9 + 1*3 + 2] = {16'h0000, 16'h0100, 16'h0000};
        run(n);
        chk("t4_latency", n, 7201);
        chk("t4_hit", dut.mem_result[4][5][47:32], 16'h0200);
        check_all("t4_all", 3);

        // Mid-CONV abort and restart
        do_reset();
        load(16'h0100, 16'h0100, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        repeat (3000) @(negedge clk);
        chk("t5_pre_done", cnndonesignal, 1'b0);
        rst = 1'b0;
        #1;
        chk("t5_rst_done", cnndonesignal, 1'b0);
        chk("t5_partial", dut.mem_result[0][0][15:0], 16'h1B00);
        chk("t5_stale", dut.mem_result[29][29][127:112], 16'h0000);
        repeat (2) @(negedge clk);
        chk("t5_rst_hold", cnndonesignal, 1'b0);
        run(n);
        chk("t5_latency", n, 7201);
        check_all("t5_all", 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/top_cnn.md
TOP_CNN -- requirements
Module: top_cnn

Interface
REQ-001 The module SHALL have exactly one clock and an asynchronous, active-low reset, with ports clk and rst.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  asynchronous active-low reset; a low level resets the module immediately.
REQ-004 cnndonesignal  output  1  high when the full 30x30x8 result is written; stays high until the next reset.
REQ-005 Internal array mem_pixel_in[32][32] SHALL be 48 bits per entry, indexed [row][col]; bits [16c+15:16c] hold input channel c (0..2).
REQ-006 Internal array mem_weight_in[72] SHALL be 48 bits per entry; index = oc*9 + ky*3 + kx, with the same channel packing as REQ-005.
REQ-007 Internal array mem_bias_in[8] SHALL be 16 bits per entry, indexed by output channel oc.
REQ-008 Internal array mem_result[30][30] SHALL be 128 bits per entry; bits [16oc+15:16oc] hold output channel oc.
REQ-009 All four arrays SHALL be plain unpacked arrays at the top_cnn scope, with these exact names, so a bench can write them and read them hierarchically.

Function
REQ-010 Every value SHALL be signed two's-complement Q8.8 (16 bits).
REQ-011 For each output position r,c (0..29) and each oc (0..7), the module SHALL compute acc = sum over ky,kx (0..2) and ch (0..2) of pixel[r+ky][c+kx].ch * weight[oc*9+ky*3+kx].ch, plus (bias[oc] << 8).
REQ-012 The accumulator SHALL be at least 37 bits signed, so that no overflow can occur before scaling.
REQ-013 The result SHALL be acc arithmetically shifted right by 8 (truncation, no rounding), then saturated to the range 0x8000..0x7FFF.
REQ-014 The FSM SHALL have three states: IDLE, CONV and DONE.
REQ-015 IDLE SHALL last exactly one cycle after reset release, then go to CONV.
REQ-016 CONV SHALL compute one (r,c,oc) result per cycle and write that 16-bit slice of mem_result on the clock edge.
REQ-017 Counter order in CONV SHALL be oc innermost, then c, then r.
REQ-018 CONV SHALL last exactly 7200 cycles.
REQ-019 After writing r=29, c=29, oc=7, the FSM SHALL enter DONE.
REQ-020 cnndonesignal SHALL be registered and go high on the first edge in DONE, i.e. 7201 edges after rst rises.
REQ-021 DONE SHALL be terminal: no further writes, and cnndonesignal stays high.
REQ-022 The input arrays SHALL be read-only to the module; they change only through external writes.

Reset
REQ-023 When rst goes low, the module SHALL immediately enter IDLE, clear the r, c and oc counters, and drive cnndonesignal to 0.
REQ-024 The arrays SHALL NOT be reset, so contents loaded while rst is low are preserved.
REQ-025 Reset asserted mid-CONV SHALL abort the computation; the next release restarts from r=c=oc=0.
REQ-026 After a mid-CONV abort, stale mem_result entries remain until they are overwritten.

Configuration
REQ-027 With macro CNN_RELU_EN defined, every saturated result below zero SHALL be written as 0x0000.
REQ-028 Without CNN_RELU_EN, the signed saturated value SHALL be written unchanged.

Structure
REQ-029 Package cnn_pkg SHALL hold:
- constants: DATA_W=16, FRAC_W=8, IN_DIM=32, OUT_DIM=30, IN_CH=3, OUT_CH=8, K=3;
- the state enum {IDLE, CONV, DONE}.
REQ-030 Sub-module cnn_pe SHALL perform the 27-term multiply-accumulate, bias add, shift, saturation and optional ReLU, combinationally.
REQ-031 top_cnn SHALL hold the FSM, the counters, the window and weight selection, and the result write.

Verification
REQ-032 All pixel and weight channels = 0x0100, all biases = 0 -> every mem_result slice = 0x1B00; cnndonesignal rises exactly 7201 edges after rst rises.
REQ-033 Pixels = 0, weights = 0, bias[3] = 0xFF00, other biases = 0x0080 ->
- oc3 slice = 0x0000 with CNN_RELU_EN, 0xFF00 without;
- every other oc slice = 0x0080.
REQ-034 Pixels = 0x7FFF and weights = 0x7FFF on all channels -> every slice = 0x7FFF (positive saturation).
REQ-035 Single nonzero input: pixel[5][7] ch1 = 0x0200; single nonzero weight: index 2*9+1*3+2 (oc2, ky=1, kx=2) ch1 = 0x0100 ->
- mem_result[4][5] oc2 = 0x0200;
- all other slices = 0 (verifies indexing).
REQ-036 Run REQ-032 stimulus, pull rst low for 2 cycles at cycle 3000 -> cnndonesignal is low during reset, then rises 7201 edges after the release with a fully correct result.
